// File: rtl/pixel_burst_packer.sv
// Packs a pixel stream into memory words, buffers them in a word FIFO and drains them as fixed-length write bursts.
// Optional SOF resynchronisation (s_pixel_sof input, sof_err output) is enabled by PIXEL_BURST_PACKER_SOF_RESYNC_EN.
module pixel_burst_packer #(
  parameter int          IMAGE_WIDTH      = 1280,
  parameter int          IMAGE_HEIGHT     = 360,
  parameter int          PIXEL_DATA_WIDTH = 16,
  parameter int          WORD_WIDTH       = 128,
  parameter int          BURST_LEN        = 16,
  parameter int          FIFO_DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_DATA_WIDTH-1:0] s_pixel_data,
  input  logic                        s_pixel_valid,
`ifdef PIXEL_BURST_PACKER_SOF_RESYNC_EN
  input  logic                        s_pixel_sof,
  output logic                        sof_err,
`endif
  output logic                        m_burst_req,
  output logic [31:0]                 m_burst_addr,
  input  logic                        m_burst_ack,
  output logic [WORD_WIDTH-1:0]       m_wr_data,
  output logic                        m_wr_valid,
  input  logic                        m_wr_ready,
  output logic                        m_wr_last,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int PPW          = WORD_WIDTH / PIXEL_DATA_WIDTH;
  localparam int PIDX_W       = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int FRAME_BURSTS = FRAME_PIXELS / (PPW * BURST_LEN);
  localparam int BIDX_W       = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W        = PTR_W + 1;
  localparam int BEAT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_BYTES  = BURST_LEN * (WORD_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  function automatic logic [31:0] burst_addr(input logic [BIDX_W-1:0] idx);
    return BASE_ADDR + 32'(idx) * 32'(BURST_BYTES);
  endfunction

  state_t                  state;
  logic [PIDX_W-1:0]       pack_idx;
  logic [PIDX_W-1:0]       slot;
  logic [WORD_WIDTH-1:0]   pack_word;
  logic [WORD_WIDTH-1:0]   word_next;
  logic                    word_done;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    launch;
  logic                    sof_resync;
  logic [WORD_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [BIDX_W-1:0]       burst_idx;
  logic [BIDX_W-1:0]       req_idx;
  logic [BEAT_W-1:0]       beat;

`ifdef PIXEL_BURST_PACKER_SOF_RESYNC_EN
  localparam int PCNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  logic [PCNT_W-1:0] pix_cnt;
  logic              sof_pend;

  assign sof_resync = s_pixel_valid && s_pixel_sof && (pix_cnt != '0);
  assign req_idx    = sof_pend ? '0 : burst_idx;

  // Frame position tracking; a misplaced SOF restarts the frame at this pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt  <= '0;
      sof_err  <= 1'b0;
      sof_pend <= 1'b0;
    end else begin
      if (s_pixel_valid) begin
        if (sof_resync)
          pix_cnt <= PCNT_W'(1);
        else if (pix_cnt == PCNT_W'(FRAME_PIXELS - 1))
          pix_cnt <= '0;
        else
          pix_cnt <= pix_cnt + PCNT_W'(1);
      end
      if (sof_resync) begin
        sof_err  <= 1'b1;
        sof_pend <= 1'b1;
      end else if (launch) begin
        sof_pend <= 1'b0;
      end
    end
  end
`else
  assign sof_resync = 1'b0;
  assign req_idx    = burst_idx;
`endif

  // Pack stage: slot the incoming pixel into the word being assembled
  assign slot      = sof_resync ? '0 : pack_idx;
  assign word_done = s_pixel_valid && (slot == PIDX_W'(PPW - 1));
  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push      = word_done && !fifo_full;
  assign pop       = m_wr_valid && m_wr_ready;
  assign launch    = (state == IDLE) && (fifo_count >= CNT_W'(BURST_LEN));

  always_comb begin
    word_next = pack_word;
    for (int k = 0; k < PPW; k++) begin
      if (slot == PIDX_W'(k))
        word_next[k*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH] = s_pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (s_pixel_valid)
      pack_word <= word_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_idx <= '0;
      overflow <= 1'b0;
    end else if (s_pixel_valid) begin
      pack_idx <= word_done ? '0 : slot + PIDX_W'(1);
      if (word_done && fifo_full)
        overflow <= 1'b1;
    end
  end

  // FIFO stage: completed words queue here until a burst drains them
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= word_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head word is masked while idle so the data bus reads zero outside bursts
  assign m_wr_data = m_wr_valid ? mem[rd_ptr] : '0;

  // Burst stage: request, then stream BURST_LEN beats from the FIFO head
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      m_burst_req  <= 1'b0;
      m_burst_addr <= '0;
      m_wr_valid   <= 1'b0;
      m_wr_last    <= 1'b0;
      frame_done   <= 1'b0;
      burst_idx    <= '0;
      beat         <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state        <= REQ;
            m_burst_req  <= 1'b1;
            m_burst_addr <= burst_addr(req_idx);
            burst_idx    <= req_idx;
          end
        end
        REQ: begin
          if (m_burst_ack) begin
            state       <= DATA;
            m_burst_req <= 1'b0;
            m_wr_valid  <= 1'b1;
            m_wr_last   <= (BURST_LEN == 1);
            beat        <= '0;
          end
        end
        DATA: begin
          if (m_wr_ready) begin
            if (m_wr_last) begin
              state      <= IDLE;
              m_wr_valid <= 1'b0;
              m_wr_last  <= 1'b0;
              if (burst_idx == BIDX_W'(FRAME_BURSTS - 1)) begin
                burst_idx  <= '0;
                frame_done <= 1'b1;
              end else begin
                burst_idx <= burst_idx + BIDX_W'(1);
              end
            end else begin
              beat      <= beat + BEAT_W'(1);
              m_wr_last <= (beat == BEAT_W'(BURST_LEN - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
